// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU memory request/ack bus plus backdoor preload port
interface mem_responder_if #(
  parameter int ADDR_W = 8
) ();
  logic              readM;
  logic              writeM;
  logic [15:0]       address;
  logic [15:0]       data_in;
  logic [15:0]       data_out;
  logic              inputReady;
  logic              busy;
  logic              err;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [15:0]       ld_data;
  modport master (
    output readM, writeM, address, data_in, ld_en, ld_addr, ld_data,
    input  data_out, inputReady, busy, err
  );
  modport slave (
    input  readM, writeM, address, data_in, ld_en, ld_addr, ld_data,
    output data_out, inputReady, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word RAM serving one CPU access at a time with fixed latency and 4-phase ack
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input logic            clk,
  input logic            reset_n,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, WAIT_DROP} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       wdata;
  logic              wr_q;
  logic              oor;
  logic [15:0]       mem [DEPTH];
  logic              req;
  logic              commit;
  logic              load;
  // A request is exactly one of read/write; RAM writes come from a completing write or an idle preload
  always_comb begin
    req    = bus.readM ^ bus.writeM;
    commit = (state == BUSY) && (cnt == 4'd0) && wr_q && !oor;
    load   = (state == IDLE) && !req && bus.ld_en;
  end
  // Access sequencer: accept, count down latency, pulse ack, then wait for the request to drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      idx            <= '0;
      wdata          <= 16'h0;
      wr_q           <= 1'b0;
      oor            <= 1'b0;
      bus.data_out   <= 16'h0;
      bus.inputReady <= 1'b0;
      bus.busy       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.readM && bus.writeM) bus.err <= 1'b1;
          if (req) begin
            state    <= BUSY;
            bus.busy <= 1'b1;
            cnt      <= 4'(LATENCY - 1);
            idx      <= bus.address[ADDR_W-1:0];
            oor      <= |bus.address[15:ADDR_W];
            wdata    <= bus.data_in;
            wr_q     <= bus.writeM;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state          <= DONE;
            bus.inputReady <= 1'b1;
            if (!wr_q) bus.data_out <= oor ? 16'h0 : mem[idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state          <= WAIT_DROP;
          bus.inputReady <= 1'b0;
        end
        WAIT_DROP: begin
          if (!bus.readM && !bus.writeM) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
      endcase
    end
  end
  // RAM array is not reset; a write aborted by reset never reaches the commit edge
  always_ff @(posedge clk) begin
    if (commit) mem[idx] <= wdata;
    else if (load) mem[bus.ld_addr] <= bus.ld_data;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against a RAM array model
module tb_mem_responder;
  localparam int AW  = 8;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  mem_responder_if #(.ADDR_W(AW)) bus ();
  mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic        rd;
    logic [15:0] data;
    int          ack_cyc;
  } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] ram [256];
  logic [15:0] last_rd = 16'h0;
  int          cyc = 0;
  int          acks = 0;
  int          checks = 0;
  int          failures = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  // monitor: every ack must match the oldest expected response in time and data
  initial forever begin
    @(negedge clk);
    if (reset_n && bus.inputReady) begin
      acks++;
      if (sb.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("ack_cycle", cyc, mon_e.ack_cyc);
        chk(mon_e.rd ? "read_data" : "data_out_hold", bus.data_out, mon_e.data);
      end
    end
  end
  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  task automatic idle_in();
    bus.readM = 1'b0; bus.writeM = 1'b0; bus.address = 16'h0; bus.data_in = 16'h0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = 16'h0;
  endtask
  task automatic access(input logic rd, input logic [15:0] addr, input logic [15:0] d, input int hold);
    exp_t e;
    logic in_r;
    int   t;
    @(negedge clk);
    in_r = (addr[15:AW] == 0);
    bus.readM = rd; bus.writeM = !rd; bus.address = addr; bus.data_in = d;
    bus.ld_en = 1'b1; bus.ld_addr = AW'($urandom); bus.ld_data = 16'($urandom);
    if (rd) last_rd = in_r ? ram[addr[AW-1:0]] : 16'h0;
    else if (in_r) ram[addr[AW-1:0]] = d;
    e.rd = rd; e.data = last_rd; e.ack_cyc = cyc + 1 + LAT;
    sb.push_back(e);
    t = acks;
    @(negedge clk);
    chk("busy_after_accept", bus.busy, 1);
    bus.address = 16'($urandom); bus.data_in = 16'($urandom);
    bus.ld_addr = AW'($urandom); bus.ld_data = 16'($urandom);
    for (int i = 0; i < 50 && acks == t; i++) @(negedge clk);
    if (acks == t) chk("ack_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    idle_in();
    @(negedge clk);
  endtask
  initial begin
    idle_in();
    repeat (3) @(negedge clk);
    chk("reset_data_out", bus.data_out, 0);
    chk("reset_inputReady", bus.inputReady, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_err", bus.err, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bus.ld_en = 1'b1; bus.ld_addr = i[AW-1:0]; bus.ld_data = 16'($urandom);
      ram[i] = bus.ld_data;
    end
    @(negedge clk);
    bus.ld_addr = 8'd5; bus.ld_data = 16'hBEEF; ram[5] = 16'hBEEF;
    @(negedge clk);
    idle_in();
    access(1'b1, 16'h0005, 16'h0, 0);
    access(1'b0, 16'h0007, 16'h1234, 0);
    access(1'b1, 16'h0007, 16'h0, 0);
    access(1'b1, 16'h0009, 16'h0, 10);
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      a = ($urandom % 8 == 0) ? 16'($urandom) : 16'($urandom % 256);
      access(1'($urandom), a, 16'($urandom), int'($urandom % 4));
    end
    access(1'b1, 16'h0100, 16'h0, 0);
    access(1'b0, 16'h0100, 16'hDEAD, 0);
    access(1'b1, 16'h0000, 16'h0, 0);
    @(negedge clk);
    bus.readM = 1'b1; bus.writeM = 1'b1;
    repeat (3) @(negedge clk);
    chk("both_busy", bus.busy, 0);
    chk("both_err", bus.err, 1);
    idle_in();
    repeat (2) @(negedge clk);
    chk("err_sticky", bus.err, 1);
    chk("err_idle_busy", bus.busy, 0);
    @(negedge clk);
    bus.writeM = 1'b1; bus.address = 16'h000C; bus.data_in = ~ram[12];
    @(negedge clk);
    chk("abort_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy_clr", bus.busy, 0);
    chk("abort_ack_clr", bus.inputReady, 0);
    chk("abort_err_clr", bus.err, 0);
    chk("abort_data_clr", bus.data_out, 0);
    last_rd = 16'h0;
    idle_in();
    @(negedge clk);
    reset_n = 1'b1;
    access(1'b1, 16'h000C, 16'h0, 0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
